// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//
// PS/2 keyboard front end for the synthesizer. It receives Set-2 scan codes
// and keeps a bitmap of held keys in the 33-bit format the synth consumes on
// its i_data bus. Bits [31:0] are note keys and bit 32 is the space/octave flag.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_ps2_clk    raw PS/2 clock (asynchronous to i_clk)
//   i_ps2_data   raw PS/2 data  (asynchronous to i_clk)
//   o_data       held-key bitmap, 1 = key down
//   o_byte       last correctly received scan byte
//   o_byte_valid one-cycle pulse when o_byte is updated
//   o_frame_err  one-cycle pulse on parity/stop error or receive timeout
module ps2_key_tracker #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    output logic [32:0] o_data,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic        o_frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state, state_next;
    logic             ps2c_s1, ps2c_s2, ps2c_prev;
    logic             ps2d_s1, ps2d_s2;
    logic             fall;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             par;
    logic [CNT_W-1:0] timer;
    logic             timeout;
    logic             frame_ok;
    logic             byte_load;
    logic             err_set;
    logic             brk, ext;

    // Set-2 make code -> bitmap index. MSB of the result flags a mapped code.
    function automatic logic [6:0] key_lookup(input logic [7:0] code);
        logic [6:0] r;
        r = 7'd0;
        case (code)
            8'h1A: r = {1'b1, 6'd0};
            8'h1B: r = {1'b1, 6'd1};
            8'h22: r = {1'b1, 6'd2};
            8'h23: r = {1'b1, 6'd3};
            8'h21: r = {1'b1, 6'd4};
            8'h2A: r = {1'b1, 6'd5};
            8'h34: r = {1'b1, 6'd6};
            8'h32: r = {1'b1, 6'd7};
            8'h33: r = {1'b1, 6'd8};
            8'h31: r = {1'b1, 6'd9};
            8'h3B: r = {1'b1, 6'd10};
            8'h3A: r = {1'b1, 6'd11};
            8'h41: r = {1'b1, 6'd12};
            8'h4B: r = {1'b1, 6'd13};
            8'h49: r = {1'b1, 6'd14};
            8'h4C: r = {1'b1, 6'd15};
            8'h4A: r = {1'b1, 6'd16};
            8'h15: r = {1'b1, 6'd17};
            8'h1E: r = {1'b1, 6'd18};
            8'h1D: r = {1'b1, 6'd19};
            8'h26: r = {1'b1, 6'd20};
            8'h24: r = {1'b1, 6'd21};
            8'h2D: r = {1'b1, 6'd22};
            8'h2E: r = {1'b1, 6'd23};
            8'h2C: r = {1'b1, 6'd24};
            8'h36: r = {1'b1, 6'd25};
            8'h35: r = {1'b1, 6'd26};
            8'h3D: r = {1'b1, 6'd27};
            8'h3C: r = {1'b1, 6'd28};
            8'h43: r = {1'b1, 6'd29};
            8'h46: r = {1'b1, 6'd30};
            8'h44: r = {1'b1, 6'd31};
            8'h29: r = {1'b1, 6'd32};
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    // Synchronizers reset high so an idle bus never looks like a falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ps2c_s1   <= 1'b1;
            ps2c_s2   <= 1'b1;
            ps2c_prev <= 1'b1;
            ps2d_s1   <= 1'b1;
            ps2d_s2   <= 1'b1;
        end else begin
            ps2c_s1   <= i_ps2_clk;
            ps2c_s2   <= ps2c_s1;
            ps2c_prev <= ps2c_s2;
            ps2d_s1   <= i_ps2_data;
            ps2d_s2   <= ps2d_s1;
        end
    end

    assign fall     = ps2c_prev & ~ps2c_s2;
    assign timeout  = (state != IDLE) && (timer == CNT_W'(TIMEOUT_CYC));
    // Stop bit high and odd parity over data plus parity bit.
    assign frame_ok = ps2d_s2 & (^{shift, par});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_load  = 1'b0;
        err_set    = 1'b0;
        if (timeout) begin
            state_next = IDLE;
            err_set    = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    if (!ps2d_s2) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (frame_ok) byte_load = 1'b1;
                    else          err_set   = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Receive datapath and watchdog.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift   <= 8'd0;
            bit_cnt <= 3'd0;
            par     <= 1'b0;
            timer   <= '0;
        end else begin
            if (state == IDLE || fall || timeout) timer <= '0;
            else                                  timer <= timer + 1'b1;

            if (fall && !timeout) begin
                case (state)
                    IDLE:   bit_cnt <= 3'd0;
                    DATA: begin
                        shift   <= {ps2d_s2, shift[7:1]};  // LSB arrives first
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par <= ps2d_s2;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_byte       <= 8'd0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= byte_load;
            o_frame_err  <= err_set;
            if (byte_load) o_byte <= shift;
        end
    end

    // Scan-code decoder: runs one cycle behind o_byte_valid. Errored frames
    // never pulse o_byte_valid, so pending prefixes survive them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= 33'd0;
            brk    <= 1'b0;
            ext    <= 1'b0;
        end else if (o_byte_valid) begin
            case (o_byte)
                8'hF0: brk <= 1'b1;
                8'hE0: ext <= 1'b1;
                8'h00, 8'hFF: begin
                    o_data <= 33'd0;
                    brk    <= 1'b0;
                    ext    <= 1'b0;
                end
                default: begin
                    if (!ext && key_lookup(o_byte)[6])
                        o_data[key_lookup(o_byte)[5:0]] <= ~brk;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed testbench for ps2_key_tracker.
module tb_ps2_key_tracker;

    localparam int TO   = 300;
    localparam int HALF = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ps2_clk = 1'b1;
    logic        i_ps2_data = 1'b1;
    logic [32:0] o_data;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        o_frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nvalid   = 0;
    int nerr     = 0;
    int nboth    = 0;
    int valid_cyc = 0;
    int chg_cyc   = 0;
    logic [32:0] prev_data = 33'd0;

    ps2_key_tracker #(.TIMEOUT_CYC(TO)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ps2_clk    (i_ps2_clk),
        .i_ps2_data   (i_ps2_data),
        .o_data       (o_data),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // Event monitor, sampled on the inactive edge.
    always @(negedge i_clk) begin
        cyc = cyc + 1;
        if (o_byte_valid === 1'b1) begin
            nvalid    = nvalid + 1;
            valid_cyc = cyc;
        end
        if (o_frame_err === 1'b1) nerr = nerr + 1;
        if (o_byte_valid === 1'b1 && o_frame_err === 1'b1) nboth = nboth + 1;
        if (o_data !== prev_data) chg_cyc = cyc;
        prev_data = o_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Sends the first nbits of a frame; bad_par flips the odd parity bit.
    task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        logic        p;
        p = (~^b) ^ bad_par;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge i_clk);
            i_ps2_data = f[i];
            wait_cyc(HALF);
            i_ps2_clk = 1'b0;
            wait_cyc(HALF);
            i_ps2_clk = 1'b1;
        end
        @(negedge i_clk);
        i_ps2_data = 1'b1;
        wait_cyc(8);
    endtask

    task automatic send(input logic [7:0] b);
        ps2_send(b, 1'b0, 11);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_data",  o_data, 0);
        check("rst_byte",  o_byte, 0);
        check("rst_valid", o_byte_valid, 0);
        check("rst_err",   o_frame_err, 0);
        i_rst_n = 1'b1;
        wait_cyc(3);

        // Make/break of Z
        send(8'h1A);
        check("z_byte",    o_byte, 8'h1A);
        check("z_data",    o_data, 33'h1);
        check("z_nvalid",  nvalid, 1);
        check("z_latency", chg_cyc - valid_cyc, 1);
        send(8'hF0);
        send(8'h1A);
        check("zbrk_data",   o_data, 33'h0);
        check("zbrk_nvalid", nvalid, 3);

        // Chord plus space
        send(8'h15);
        send(8'h4A);
        send(8'h29);
        check("chord_data", o_data, 33'h1_0003_0000);
        send(8'hF0);
        send(8'h15);
        check("chord_brk", o_data, 33'h1_0001_0000);

        // Extended codes ignored
        send(8'hE0);
        send(8'h1A);
        check("ext_make", o_data, 33'h1_0001_0000);
        send(8'hE0);
        send(8'hF0);
        send(8'h1A);
        check("ext_brk", o_data, 33'h1_0001_0000);
        send(8'h1A);
        check("ext_after", o_data, 33'h1_0001_0001);
        check("ext_nvalid", nvalid, 14);

        // Overrun clear, then parity error
        send(8'hFF);
        check("ovr1_data", o_data, 33'h0);
        ps2_send(8'h1A, 1'b1, 11);
        check("par_err",    nerr, 1);
        check("par_nvalid", nvalid, 15);
        check("par_byte",   o_byte, 8'hFF);
        check("par_data",   o_data, 33'h0);
        send(8'h1A);
        check("par_next", o_data, 33'h1);
        // Break prefix survives an errored frame
        send(8'hF0);
        ps2_send(8'h1A, 1'b1, 11);
        check("par_err2", nerr, 2);
        send(8'h1A);
        check("brk_kept", o_data, 33'h0);

        // Timeout on a partial frame
        ps2_send(8'h1B, 1'b0, 5);
        wait_cyc(TO + 10);
        check("to_err",  nerr, 3);
        check("to_idle", dut.state, 0);
        send(8'h1B);
        check("to_next", o_data, 33'h2);

        // Overrun with keys held
        send(8'h1A);
        send(8'h2A);
        send(8'h29);
        check("held3", o_data, 33'h1_0000_0023);
        send(8'hFF);
        check("ovr2_data", o_data, 33'h0);

        // Asynchronous reset mid-frame
        send(8'h1A);
        send(8'h2A);
        send(8'h29);
        check("held3b", o_data, 33'h1_0000_0021);
        ps2_send(8'h1B, 1'b0, 3);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check("async_data", o_data, 33'h0);
        check("async_byte", o_byte, 8'h0);
        wait_cyc(3);
        i_rst_n = 1'b1;
        wait_cyc(3);
        send(8'h1B);
        check("post_rst_byte", o_byte, 8'h1B);
        check("post_rst_data", o_data, 33'h2);
        check("final_nvalid", nvalid, 27);
        check("final_nerr",   nerr, 3);
        check("never_both",   nboth, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
